// File: rtl/ota_bitstream_decoder.sv
// Duty-cycle decoder for the OTA/comparator bitstream: it synchronises cmp_in and counts
// ones over a 32/64/128/256-cycle window, then presents an 8-bit saturated code with a strobe.
`timescale 1ns/1ps

module ota_bitstream_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmp_in,
    input  logic       start,
    input  logic [1:0] win_sel,
    input  logic       continuous,
    output logic [7:0] result,
    output logic       valid,
    output logic       busy,
    output logic       sat
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    logic [0:0]             state_r;
    logic [0:0]             state_s;
    logic [1:0]             win_sel_r;
    logic [1:0]             win_sel_s;
    logic                   cont_r;
    logic                   cont_s;
    logic [8:0]             acc_r;
    logic [8:0]             acc_s;
    logic [7:0]             idx_r;
    logic [7:0]             idx_s;
    logic [7:0]             result_s;
    logic                   sat_s;
    logic                   valid_s;
    logic [8:0]             sum_s;
    logic                   last_s;

    // Index of the final sample in a window of 32 << ws cycles.
    function automatic logic [7:0] last_idx(input logic [1:0] ws);
        logic [7:0] li;
        case (ws)
            2'd0:    li = 8'd31;
            2'd1:    li = 8'd63;
            2'd2:    li = 8'd127;
            2'd3:    li = 8'd255;
            default: li = 8'd31;
        endcase
        return li;
    endfunction

    // A full-scale 256-cycle window of ones clamps to 255.
    function automatic logic [7:0] sat_code(input logic [8:0] sum);
        logic [7:0] code;
        if (sum > 9'd255) begin
            code = 8'd255;
        end else begin
            code = sum[7:0];
        end
        return code;
    endfunction

    assign s_s    = sync_r[SYNC_STAGES-1];
    assign sum_s  = acc_r + {8'd0, s_s};
    assign last_s = (idx_r == last_idx(win_sel_r));
    assign busy   = (state_r == ST_RUN);

    // Input synchroniser: only its last stage feeds the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], cmp_in};
        end
    end

    // Next-state, accumulator and result computation.
    always_comb begin
        state_s   = state_r;
        win_sel_s = win_sel_r;
        cont_s    = cont_r;
        acc_s     = acc_r;
        idx_s     = idx_r;
        result_s  = result;
        sat_s     = sat;
        valid_s   = 1'b0;
        if (!ena) begin
            state_s = ST_IDLE;
            acc_s   = 9'd0;
            idx_s   = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s   = ST_RUN;
                        win_sel_s = win_sel;
                        cont_s    = continuous;
                        acc_s     = 9'd0;
                        idx_s     = 8'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (last_s) begin
                        result_s = sat_code(sum_s);
                        sat_s    = (sum_s == 9'd256);
                        valid_s  = 1'b1;
                        acc_s    = 9'd0;
                        idx_s    = 8'd0;
                        // Continuous mode rolls straight into the next window with no gap cycle.
                        if (cont_r) begin
                            state_s   = ST_RUN;
                            win_sel_s = win_sel;
                            cont_s    = continuous;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        acc_s = sum_s;
                        idx_s = idx_r + 8'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    acc_s   = 9'd0;
                    idx_s   = 8'd0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            win_sel_r <= 2'd0;
            cont_r    <= 1'b0;
            acc_r     <= 9'd0;
            idx_r     <= 8'd0;
            result    <= 8'd0;
            sat       <= 1'b0;
            valid     <= 1'b0;
        end else begin
            state_r   <= state_s;
            win_sel_r <= win_sel_s;
            cont_r    <= cont_s;
            acc_r     <= acc_s;
            idx_r     <= idx_s;
            result    <= result_s;
            sat       <= sat_s;
            valid     <= valid_s;
        end
    end

endmodule

// File: tb/tb_ota_bitstream_decoder.sv
// Directed self-checking bench for ota_bitstream_decoder; inputs change and outputs are
// sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_ota_bitstream_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cmp_in;
    logic       start;
    logic [1:0] win_sel;
    logic       continuous;
    logic [7:0] result;
    logic       valid;
    logic       busy;
    logic       sat;

    int checks   = 0;
    int failures = 0;
    int pat      = 0;
    int phase    = 0;

    always #5 clk = ~clk;

    ota_bitstream_decoder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cmp_in     (cmp_in),
        .start      (start),
        .win_sel    (win_sel),
        .continuous (continuous),
        .result     (result),
        .valid      (valid),
        .busy       (busy),
        .sat        (sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Patterns: 0 low, 1 high, 2 alternating, 3 one-in-four.
    task automatic drive_pat();
        case (pat)
            0:       cmp_in = 1'b0;
            1:       cmp_in = 1'b1;
            2:       cmp_in = phase[0];
            default: cmp_in = ((phase % 4) == 0);
        endcase
        phase++;
    endtask

    task automatic step();
        @(negedge clk);
        drive_pat();
    endtask

    // Preload with pattern pre, switch to pw in the start cycle, wait for the strobe.
    task automatic window(input logic [1:0] ws, input int pre, input int pw, input int restart_at,
                          output int lat, output int bcnt, output logic b_after);
        int cnt;
        win_sel = ws;
        pat = pre;
        repeat (4) step();
        if (pw != pre) begin
            pat = pw;
            drive_pat();
        end
        start = 1'b1;
        step();
        start = 1'b0;
        cnt  = 1;
        bcnt = 0;
        while (valid !== 1'b1 && cnt < 600) begin
            if (busy === 1'b1) bcnt++;
            start = (cnt == restart_at) ? 1'b1 : 1'b0;
            step();
            start = 1'b0;
            cnt++;
        end
        lat = cnt - 1;
        b_after = busy;
    endtask

    task automatic next_valid(input int chg_at, output int gap, output int blow);
        gap  = 0;
        blow = 0;
        do begin
            if (gap == chg_at) win_sel = 2'd0;
            step();
            gap++;
            if (busy !== 1'b1) blow++;
        end while (valid !== 1'b1 && gap < 600);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   bc;
        int   gap;
        int   bl;
        int   vcnt;
        logic ba;

        rst_n = 1'b0; ena = 1'b0; cmp_in = 1'b0; start = 1'b0;
        continuous = 1'b0; win_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 8'd0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sat", sat, 1'b0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // All ones, 32-cycle window.
        window(2'd0, 1, 1, 0, lat, bc, ba);
        chk("ones32_latency", lat, 32);
        chk("ones32_result", result, 8'd32);
        chk("ones32_sat", sat, 1'b0);
        chk("ones32_busy_cycles", bc, 32);
        chk("ones32_busy_after", ba, 1'b0);
        step();
        chk("ones32_valid_one_cycle", valid, 1'b0);

        // All ones, 256-cycle window saturates.
        window(2'd3, 1, 1, 0, lat, bc, ba);
        chk("ones256_latency", lat, 256);
        chk("ones256_result", result, 8'd255);
        chk("ones256_sat", sat, 1'b1);

        window(2'd0, 0, 0, 0, lat, bc, ba);
        chk("zeros32_result", result, 8'd0);
        chk("zeros32_sat", sat, 1'b0);

        window(2'd1, 2, 2, 0, lat, bc, ba);
        chk("alt64_latency", lat, 64);
        chk("alt64_result", result, 8'd32);

        window(2'd2, 3, 3, 0, lat, bc, ba);
        chk("quarter128_latency", lat, 128);
        chk("quarter128_result", result, 8'd32);

        // start pulsed mid-window must not restart or stretch it.
        window(2'd1, 1, 1, 10, lat, bc, ba);
        chk("restart_latency", lat, 64);
        chk("restart_result", result, 8'd64);
        chk("restart_busy_cycles", bc, 64);

        // Continuous mode, with win_sel changed mid-window.
        continuous = 1'b1;
        window(2'd1, 1, 1, 0, lat, bc, ba);
        chk("cont_first_latency", lat, 64);
        chk("cont_first_result", result, 8'd64);
        chk("cont_busy_at_strobe", ba, 1'b1);
        next_valid(-1, gap, bl);
        chk("cont_gap1", gap, 64);
        chk("cont_result1", result, 8'd64);
        chk("cont_busy_low1", bl, 0);
        next_valid(10, gap, bl);
        chk("cont_gap_change", gap, 64);
        chk("cont_busy_low2", bl, 0);
        next_valid(-1, gap, bl);
        chk("cont_gap32a", gap, 32);
        chk("cont_result32", result, 8'd32);
        chk("cont_busy_low3", bl, 0);
        next_valid(-1, gap, bl);
        chk("cont_gap32b", gap, 32);

        continuous = 1'b0;
        ena = 1'b0;
        step();
        chk("ena_off_busy", busy, 1'b0);
        chk("ena_off_valid", valid, 1'b0);

        // Drop ena partway through a 64-cycle window.
        ena = 1'b1;
        win_sel = 2'd1;
        pat = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        chk("abort_busy_before", busy, 1'b1);
        ena = 1'b0;
        step();
        chk("abort_busy_after", busy, 1'b0);
        ena = 1'b1;
        vcnt = 0;
        bc = 0;
        repeat (80) begin
            step();
            if (valid === 1'b1) vcnt++;
            if (busy === 1'b1) bc++;
        end
        chk("abort_no_valid", vcnt, 0);
        chk("abort_idle", bc, 0);
        chk("abort_result_held", result, 8'd32);

        // cmp_in rises in the same cycle start is asserted: first sample still sees 0.
        window(2'd0, 0, 1, 0, lat, bc, ba);
        chk("sync_latency_result", result, 8'd31);

        // Asynchronous reset mid-window.
        win_sel = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("prereset_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_result", result, 8'd0);
        chk("async_rst_valid", valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_sat", sat, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        bc = 0;
        repeat (40) begin
            step();
            if (valid === 1'b1) vcnt++;
            if (busy === 1'b1) bc++;
        end
        chk("post_rst_no_valid", vcnt, 0);
        chk("post_rst_idle", bc, 0);
        chk("post_rst_result", result, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
